sdr_req_arb: RTL and testbench

SDR_REQ_ARB -- requirements
Module: sdr_req_arb

---
 rtl/sdr_req_arb_pkg.sv | 17 +
 rtl/sdr_req_arb_if.sv | 37 +++
 rtl/sdr_req_arb_rr_pick.sv | 27 ++
 rtl/sdr_req_arb.sv | 143 ++++++++++++++
 tb/tb_sdr_req_arb.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_req_arb_pkg.sv
// Shared definitions for the SDRAM host request arbiter: address/burst widths,
// timeout default and the arbiter state encoding.
package sdr_req_arb_pkg;

  localparam int U_ADDR_MSB = 22;
  localparam int BL_W = 9;
  localparam logic [7:0] TMO_DEFAULT = 8'd200;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_REQ  = 3'd2,
    ST_BUSY = 3'd3,
    ST_GAP  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdr_req_arb_if.sv
// Host-side and controller-side signal bundle of the request arbiter.
interface sdr_req_arb_if
  import sdr_req_arb_pkg::*;
#(
  parameter int NPORT = 4
) ();

  // Handshake: a host raises h_req with h_wr_n/h_addr/h_bl stable and holds
  // it until h_done; h_gnt marks the owner. The arbiter holds sdr_req with
  // stable u_addr/bl/sdr_req_wr_n until req_ack, then until xfer_done.
  // h_done and tmo_err are single-cycle pulses.
  logic                             init_done;
  logic [NPORT-1:0]                 h_req;
  logic [NPORT-1:0]                 h_wr_n;
  logic [NPORT*(U_ADDR_MSB+1)-1:0]  h_addr;
  logic [NPORT*BL_W-1:0]            h_bl;
  logic [NPORT-1:0]                 h_gnt;
  logic [NPORT-1:0]                 h_done;
  logic                             tmo_err;
  logic                             sdr_req;
  logic                             sdr_req_wr_n;
  logic [U_ADDR_MSB:0]              u_addr;
  logic [BL_W-1:0]                  bl;
  logic                             req_ack;
  logic                             xfer_done;

  modport slave (
    input  init_done, h_req, h_wr_n, h_addr, h_bl, req_ack, xfer_done,
    output h_gnt, h_done, tmo_err, sdr_req, sdr_req_wr_n, u_addr, bl
  );

  modport master (
    output init_done, h_req, h_wr_n, h_addr, h_bl, req_ack, xfer_done,
    input  h_gnt, h_done, tmo_err, sdr_req, sdr_req_wr_n, u_addr, bl
  );

endinterface

// File: rtl/sdr_req_arb_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_pick #(
  parameter int NPORT = 4,
  parameter int IW    = 2
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [NPORT-1:0] o_win
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NPORT; k++) begin
      w_idx = (int'(i_last) + k) % NPORT;
      if (!w_found && i_req[w_idx[IW-1:0]]) begin
        o_win[w_idx[IW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdr_req_arb.sv
// SDRAM request arbiter: round-robin grant of NPORT hosts onto one controller
// request channel, with req_ack timeout and a one-cycle gap between requests.
module sdr_req_arb
  import sdr_req_arb_pkg::*;
#(
  parameter int         NPORT = 4,
  parameter logic [7:0] TMO   = TMO_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  sdr_req_arb_if.slave bus,
  output arb_state_e   o_state
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int AW = U_ADDR_MSB + 1;

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_win_idx;
  logic [NPORT-1:0] r_gnt;
  logic [NPORT-1:0] r_done;
  logic [NPORT-1:0] w_win;
  logic [NPORT-1:0] w_gnt;
  logic             r_wr_n;
  logic             r_tmo;
  logic             w_win_wr_n;
  logic             w_tmo_hit;
  logic             w_done_hit;
  logic             w_sdr_req;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    w_win_addr;
  logic [BL_W-1:0]  r_bl;
  logic [BL_W-1:0]  w_win_bl;
  logic [7:0]       r_wait;

  rr_pick #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_rr_pick (
    .i_req  (bus.h_req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_comb begin
    w_win_wr_n = 1'b0;
    w_win_addr = '0;
    w_win_bl   = '0;
    w_win_idx  = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (w_win[p]) begin
        w_win_wr_n = bus.h_wr_n[p];
        w_win_addr = bus.h_addr[p*AW +: AW];
        w_win_bl   = bus.h_bl[p*BL_W +: BL_W];
        w_win_idx  = IW'(p);
      end
    end
  end

  // A same-cycle req_ack + xfer_done in REQ completes the transfer directly.
  assign w_done_hit = bus.init_done & bus.xfer_done &
                      ((r_state == ST_BUSY) | ((r_state == ST_REQ) & bus.req_ack));
  assign w_tmo_hit  = bus.init_done & ~bus.req_ack & (r_state == ST_REQ) &
                      (r_wait == TMO - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.init_done && (|bus.h_req)) w_next = ST_ARB;
      ST_ARB: begin
        if (!bus.init_done) w_next = ST_GAP;
        else if (|w_win)    w_next = ST_REQ;
        else                w_next = ST_IDLE;
      end
      ST_REQ: begin
        if (!bus.init_done) w_next = ST_GAP;
        else if (bus.req_ack) w_next = bus.xfer_done ? ST_GAP : ST_BUSY;
        else if (w_tmo_hit) w_next = ST_GAP;
      end
      ST_BUSY: if (!bus.init_done || bus.xfer_done) w_next = ST_GAP;
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= IW'(NPORT - 1);
      r_gnt  <= '0;
      r_wr_n <= 1'b0;
      r_addr <= '0;
      r_bl   <= '0;
      r_wait <= '0;
      r_done <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_done <= '0;
      r_tmo  <= 1'b0;
      if (r_state == ST_ARB && w_next == ST_REQ) begin
        r_last <= w_win_idx;
        r_gnt  <= w_win;
        r_wr_n <= w_win_wr_n;
        r_addr <= w_win_addr;
        r_bl   <= w_win_bl;
        r_wait <= '0;
      end else if (r_state == ST_REQ) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_done_hit) r_done <= r_gnt;
      if (w_tmo_hit)  r_tmo  <= 1'b1;
    end
  end

  always_comb begin
    w_sdr_req = 1'b0;
    w_gnt     = '0;
    case (r_state)
      ST_ARB: if (bus.init_done) w_gnt = w_win;
      ST_REQ, ST_BUSY: begin
        w_sdr_req = 1'b1;
        w_gnt     = r_gnt;
      end
      default: ;
    endcase
  end

  assign bus.sdr_req      = w_sdr_req;
  assign bus.h_gnt        = w_gnt;
  assign bus.h_done       = r_done;
  assign bus.tmo_err      = r_tmo;
  assign bus.sdr_req_wr_n = r_wr_n;
  assign bus.u_addr       = r_addr;
  assign bus.bl           = r_bl;
  assign o_state          = r_state;

endmodule

// File: tb/tb_sdr_req_arb.sv
// Directed bench for sdr_req_arb: transaction-level reference model, per-cycle
// compare, grant-order scoreboard and hand-computed literal expectations.
module tb_sdr_req_arb;
  import sdr_req_arb_pkg::*;

  localparam int TB_TMO = 200;
  localparam int M_IDLE = 0;
  localparam int M_ARB  = 1;
  localparam int M_REQ  = 2;
  localparam int M_BUSY = 3;
  localparam int M_GAP  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  arb_state_e dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_q[$];

  sdr_req_arb_if #(.NPORT(4)) bus ();

  sdr_req_arb #(
    .NPORT (4),
    .TMO   (8'd200)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog no finish by t=%0t", $time);
    $fatal(1);
  end

  // reference model: one transfer at a time, winner = next requester after the last one served
  int         m_st = M_IDLE;
  int         m_last = 3;
  int         m_port = 0;
  int         m_wait = 0;
  logic       m_wr_n = 1'b0;
  logic [22:0] m_addr = '0;
  logic [8:0] m_bl = '0;
  logic [3:0] m_done = '0;
  logic       m_tmo = 1'b0;

  function automatic int rr_winner(input logic [3:0] req, input int last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int p);
    return 4'b0001 << p;
  endfunction

  function automatic logic [22:0] port_addr(input int p);
    return bus.h_addr[p*23 +: 23];
  endfunction

  function automatic logic [8:0] port_bl(input int p);
    return bus.h_bl[p*9 +: 9];
  endfunction

  function automatic logic [3:0] exp_gnt();
    int w = rr_winner(bus.h_req, m_last);
    if (m_st == M_ARB && bus.init_done && w >= 0) return onehot(w);
    if (m_st == M_REQ || m_st == M_BUSY) return onehot(m_port);
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= M_IDLE; m_last <= 3; m_port <= 0; m_wait <= 0;
      m_wr_n <= 1'b0; m_addr <= '0; m_bl <= '0; m_done <= '0; m_tmo <= 1'b0;
    end else begin
      m_done <= '0;
      m_tmo  <= 1'b0;
      case (m_st)
        M_IDLE: if (bus.init_done && (bus.h_req != 4'b0)) m_st <= M_ARB;
        M_ARB: begin
          if (!bus.init_done) m_st <= M_GAP;
          else if (rr_winner(bus.h_req, m_last) < 0) m_st <= M_IDLE;
          else begin
            m_port <= rr_winner(bus.h_req, m_last);
            m_last <= rr_winner(bus.h_req, m_last);
            m_wr_n <= bus.h_wr_n[rr_winner(bus.h_req, m_last)];
            m_addr <= port_addr(rr_winner(bus.h_req, m_last));
            m_bl   <= port_bl(rr_winner(bus.h_req, m_last));
            m_wait <= 0;
            m_st   <= M_REQ;
          end
        end
        M_REQ: begin
          if (!bus.init_done) m_st <= M_GAP;
          else if (bus.req_ack) begin
            if (bus.xfer_done) begin m_done <= onehot(m_port); m_st <= M_GAP; end
            else m_st <= M_BUSY;
          end else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 == TB_TMO) begin m_tmo <= 1'b1; m_st <= M_GAP; end
          end
        end
        M_BUSY: begin
          if (!bus.init_done) m_st <= M_GAP;
          else if (bus.xfer_done) begin m_done <= onehot(m_port); m_st <= M_GAP; end
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // scoreboard / checks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [3:0] prev_gnt = 4'b0;
    forever begin
      @(negedge clk);
      chk("sdr_req", 64'(bus.sdr_req), 64'(m_st == M_REQ || m_st == M_BUSY));
      chk("h_gnt", 64'(bus.h_gnt), 64'(exp_gnt()));
      chk("h_done", 64'(bus.h_done), 64'(m_done));
      chk("tmo_err", 64'(bus.tmo_err), 64'(m_tmo));
      chk("u_addr", 64'(bus.u_addr), 64'(m_addr));
      chk("bl", 64'(bus.bl), 64'(m_bl));
      chk("sdr_req_wr_n", 64'(bus.sdr_req_wr_n), 64'(m_wr_n));
      if (bus.h_gnt != 4'b0 && prev_gnt == 4'b0) begin
        if (exp_q.size() == 0) chk("grant_unexpected", 64'(bus.h_gnt), 64'(0));
        else chk("grant_order", 64'(bus.h_gnt), 64'(onehot(int'(exp_q.pop_front()))));
      end
      prev_gnt = bus.h_gnt;
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic host_set(input int p, input logic wr_n, input logic [22:0] addr, input logic [8:0] bl);
    bus.h_wr_n[p] = wr_n;
    bus.h_addr[p*23 +: 23] = addr;
    bus.h_bl[p*9 +: 9] = bl;
  endtask

  task automatic serve(input int ack_dly, input int xfer_dly, input logic same);
    int n = 0;
    while (!bus.sdr_req && n < 50) begin tick(1); n++; end
    chk("serve_wait_sdr_req", 64'(bus.sdr_req), 64'(1));
    if (ack_dly > 0) tick(ack_dly);
    bus.req_ack = 1'b1;
    bus.xfer_done = same;
    tick(1);
    bus.req_ack = 1'b0;
    bus.xfer_done = 1'b0;
    if (!same) begin
      if (xfer_dly > 0) tick(xfer_dly);
      bus.xfer_done = 1'b1;
      tick(1);
      bus.xfer_done = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    bus.init_done = 1'b0; bus.h_req = '0; bus.h_wr_n = '1; bus.h_addr = '0;
    bus.h_bl = '0; bus.req_ack = 1'b0; bus.xfer_done = 1'b0;
    for (int p = 0; p < 4; p++) host_set(p, 1'b1, 23'h100 * 23'(p + 1), 9'(p + 8));
    fork
      compare_loop();
    join_none

    // reset values
    tick(3);
    chk("rst_sdr_req", 64'(bus.sdr_req), 64'(0));
    chk("rst_h_gnt", 64'(bus.h_gnt), 64'(0));
    chk("rst_h_done", 64'(bus.h_done), 64'(0));
    chk("rst_tmo_err", 64'(bus.tmo_err), 64'(0));
    chk("rst_u_addr", 64'(bus.u_addr), 64'(0));
    chk("rst_bl", 64'(bus.bl), 64'(0));
    chk("rst_wr_n", 64'(bus.sdr_req_wr_n), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    bus.init_done = 1'b1;
    tick(1);

    // ports 0 and 2 together: 0 first, then 2; low gap spans GAP, IDLE, ARB
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    bus.h_req = 4'b0101;
    tick(2);
    chk("p02_first_gnt", 64'(bus.h_gnt), 64'(4'b0001));
    serve(0, 0, 1'b1);
    chk("p02_same_cycle_done", 64'(bus.h_done), 64'(4'b0001));
    bus.h_req[0] = 1'b0;
    cnt = 1;
    for (int i = 0; i < 20 && !bus.sdr_req; i++) begin
      tick(1);
      if (!bus.sdr_req) cnt++;
    end
    chk("p02_low_cycles", 64'(cnt), 64'(3));
    chk("p02_second_gnt", 64'(bus.h_gnt), 64'(4'b0100));
    serve(1, 1, 1'b0);
    chk("p02_second_done", 64'(bus.h_done), 64'(4'b0100));
    bus.h_req[2] = 1'b0;
    tick(1);

    // port 1 write: 2-cycle latency, latched fields, h_done one cycle after xfer_done
    exp_q.push_back(2'd1);
    host_set(1, 1'b0, 23'h1A2B3C, 9'h004);
    bus.h_req = 4'b0010;
    tick(1);
    chk("p1_no_req_at_1", 64'(bus.sdr_req), 64'(0));
    chk("p1_arb_gnt", 64'(bus.h_gnt), 64'(4'b0010));
    tick(1);
    chk("p1_sdr_req", 64'(bus.sdr_req), 64'(1));
    chk("p1_wr_n", 64'(bus.sdr_req_wr_n), 64'(0));
    chk("p1_u_addr", 64'(bus.u_addr), 64'(23'h1A2B3C));
    chk("p1_bl", 64'(bus.bl), 64'(9'h004));
    serve(0, 2, 1'b0);
    chk("p1_done", 64'(bus.h_done), 64'(4'b0010));
    bus.h_req = 4'b0;
    tick(1);
    chk("p1_done_pulse_end", 64'(bus.h_done), 64'(0));

    // stray xfer_done in IDLE and in REQ before ack; port 3 drops h_req in BUSY
    bus.xfer_done = 1'b1; tick(1); bus.xfer_done = 1'b0; tick(1);
    chk("stray_idle_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.push_back(2'd3);
    bus.h_req = 4'b1000;
    tick(2);
    bus.xfer_done = 1'b1; tick(1); bus.xfer_done = 1'b0;
    chk("stray_req_state", 64'(dbg_state), 64'(ST_REQ));
    bus.req_ack = 1'b1; tick(1); bus.req_ack = 1'b0;
    bus.h_req = 4'b0;
    tick(2);
    bus.xfer_done = 1'b1; tick(1); bus.xfer_done = 1'b0;
    chk("p3_done_after_drop", 64'(bus.h_done), 64'(4'b1000));
    tick(1);

    // req_ack never comes: tmo_err 200 cycles after REQ entry, no h_done
    exp_q.push_back(2'd2);
    bus.h_req = 4'b0100;
    cnt = 0;
    while (!bus.sdr_req && cnt < 10) begin tick(1); cnt++; end
    cnt = 0;
    while (!bus.tmo_err && cnt < 300) begin tick(1); cnt++; end
    chk("tmo_latency", 64'(cnt), 64'(TB_TMO));
    chk("tmo_no_done", 64'(bus.h_done), 64'(0));
    bus.h_req = 4'b0;
    tick(1);
    chk("tmo_back_idle", 64'(dbg_state), 64'(ST_IDLE));

    // init_done falls in BUSY: abort without h_done, no grant while low
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    bus.h_req = 4'b0001;
    tick(2);
    bus.req_ack = 1'b1; tick(1); bus.req_ack = 1'b0;
    bus.init_done = 1'b0;
    tick(1);
    chk("init_abort_no_done", 64'(bus.h_done), 64'(0));
    chk("init_abort_sdr_req", 64'(bus.sdr_req), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("gnt_while_no_init", 64'(bus.h_gnt), 64'(0));
    end
    bus.init_done = 1'b1;
    serve(1, 1, 1'b0);
    chk("init_restored_done", 64'(bus.h_done), 64'(4'b0001));
    bus.h_req = 4'b0;
    tick(1);

    // reset_n pulsed low mid-cycle during BUSY drops sdr_req at once
    exp_q.push_back(2'd1);
    bus.h_req = 4'b0010;
    tick(2);
    bus.req_ack = 1'b1; tick(1); bus.req_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_sdr_req", 64'(bus.sdr_req), 64'(0));
    chk("async_rst_h_gnt", 64'(bus.h_gnt), 64'(0));
    bus.h_req = 4'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // all four ports continuously: 0,1,2,3,0
    for (int p = 0; p < 4; p++) host_set(p, p[0], 23'h7F000 + 23'(p), 9'(16 * (p + 1)));
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    bus.h_req = 4'b1111;
    for (int t = 0; t < 5; t++) serve(t % 3, t % 2, 1'b0);
    bus.h_req = 4'b0;
    tick(3);
    chk("grant_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
